mdiv_seq_ctrl: RTL and testbench
================================

Name: mdiv_seq_ctrl

Overview:
- Command sequencer directly upstream and downstream of the 256-bit modular inverse/division core.
- Accepts one command plus a 32-bit operand word stream and loads p, a and (division only) b into the core.
- Pulses the core start, waits for completion, then drains the 8 result words to a downstream valid/ready stream tagged with last.

Parameters:
- WORDS, 8, 32-bit words per 256-bit operand/result.
- TIMEOUT, 65535, max cycles in WAIT before error; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  1 = modular inverse, 0 = modular division; captured on command handshake.
- in_valid  in  1  operand word valid.
- in_ready  out  1  high in LOAD_P/LOAD_A/LOAD_B.
- in_data  in  32  operand word; least-significant word first; order p, a, b.
- datain  out  32  registered word to core.
- loadp  out  1  registered strobe; core shifts datain into p.
- loada  out  1  registered strobe; core shifts datain into a.
- loadb  out  1  registered strobe; core shifts datain into b.
- minv_mdiv  out  1  registered copy of captured cmd_op; held stable from command to DONE.
- minv_mdiv_en  out  1  single-cycle start pulse.
- minv_mdiv_rdy  in  1  core completion level.
- core_out_valid  in  1  core result word valid.
- core_out_ready  out  1  = res_ready while in DRAIN, else 0.
- result_out  in  32  core result word.
- res_valid  out  1  = core_out_valid while in DRAIN, else 0.
- res_data  out  32  = result_out (pass-through).
- res_last  out  1  res_valid && word count == WORDS-1.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout flag; cleared on next accepted command.

Behaviour:
- Reset (rst low, async): state = IDLE; word count = 0; timer = 0.
- Reset values: datain = 0, all load strobes = 0, minv_mdiv = 1, minv_mdiv_en = 0, err = 0, rdy_d = 0.
- IDLE → LOAD_P on cmd_valid. Captures cmd_op, clears err and count.
- LOAD_P, LOAD_A, LOAD_B: each in_valid && in_ready fire registers datain <= in_data and the matching strobe for exactly one cycle (latency 1). Strobes are 0 on non-fire cycles, so gaps in in_valid are allowed. Count increments per fire.
- On fire WORDS-1, count wraps to 0 and the state advances:
  - LOAD_P → LOAD_A.
  - LOAD_A → LOAD_B if op = 0, else START.
  - LOAD_B → START.
- START: one cycle; minv_mdiv_en = 1 is registered, so the pulse is visible in the cycle after the last strobe. → WAIT, timer cleared.
- WAIT: rdy_d is the registered minv_mdiv_rdy.
  - Rising edge (rdy && !rdy_d) → DRAIN. A level left high from a previous op is ignored.
  - Timer reaching TIMEOUT → ERR.
  - Timer increments each cycle.
- DRAIN: combinational pass-through between core and res_*. Count increments per res_valid && res_ready. On fire with count = WORDS-1 → DONE.
- DONE: one cycle → IDLE; cmd_ready returns the following cycle.
- ERR: err <= 1; one cycle → IDLE. No result words are emitted. Downstream must not wait for res_last.
- A new command is never accepted while busy; cmd_valid is ignored outside IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all strobes low. A core start pulse already issued is not retracted; the core is reset by the same rst.

Decomposition:
- Shared package mdiv_pkg:
  - state enum (IDLE, LOAD_P, LOAD_A, LOAD_B, START, WAIT, DRAIN, DONE, ERR), 4-bit encoding.
  - OP_MINV = 1'b1, OP_MDIV = 1'b0.
  - WORD_W = 32.
- Sub-module: mdiv_word_cnt (modulo-WORDS counter with enable, clear and wrap output), reused for the load and drain phases.
- The timeout counter stays inline.

Test Plan:
- Inverse: op = 1; p, a words 0x1..0x8, 0x11..0x18 sent back-to-back → loadp then loada high 8 cycles each with datain matching one cycle later; loadb never high; one en pulse; core rdy rises 100 cycles later → 8 res words, res_last only on the 8th, busy low after DONE.
- Division: op = 0 → 24 strobes in order p, a, b; minv_mdiv = 0 throughout; en pulse one cycle after the 8th loadb.
- Backpressure: in_valid toggles every other cycle; res_ready low for 3 cycles mid-drain → strobe count still exactly 8 per operand; no word lost or duplicated; core_out_ready tracks res_ready.
- Stale rdy: minv_mdiv_rdy held high entering WAIT, drops, rises again at +50 → DRAIN entered only at the second rise.
- Timeout: TIMEOUT = 20, rdy never rises → err = 1 at cycle 21 of WAIT, return to IDLE, no res_valid; next command clears err.
- Reset mid-LOAD_A (after 3 words) → outputs at reset values immediately; a fresh command completes normally.

Source files
------------

// File: rtl/mdiv_pkg.sv
// Shared types and constants for the modular inverse/division command sequencer.
package mdiv_pkg;

    localparam int   WORD_W  = 32;
    localparam logic OP_MINV = 1'b1;
    localparam logic OP_MDIV = 1'b0;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_P = 4'd1,
        LOAD_A = 4'd2,
        LOAD_B = 4'd3,
        START  = 4'd4,
        WAIT   = 4'd5,
        DRAIN  = 4'd6,
        DONE   = 4'd7,
        ERR    = 4'd8
    } state_t;

endpackage

// File: rtl/mdiv_word_cnt.sv
// Modulo-WORDS word counter. wrap is high on the enabled cycle that rolls the
// count from WORDS-1 back to 0; clear has priority over enable.
module mdiv_word_cnt
    import mdiv_pkg::*;
#(
    parameter int WORDS = 8,
    parameter int CW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    // Terminal-count detect qualified by enable.
    assign wrap = en && (cnt == LAST);

    // Counter register: clear, otherwise advance and roll over on enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdiv_seq_ctrl.sv
// Command sequencer around the 256-bit modular inverse/division core: loads
// p, a and (division only) b word by word, starts the core, waits for a
// rising completion edge and drains the result words downstream.
//
// Handshakes (cmd_*, in_*, core_out_*/res_*): a transfer happens on a rising
// clk edge where valid && ready are both high; ready never depends on valid,
// and a source holds valid/data until the transfer completes.
module mdiv_seq_ctrl
    import mdiv_pkg::*;
#(
    parameter int WORDS   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [WORD_W-1:0] datain,
    output logic              loadp,
    output logic              loada,
    output logic              loadb,
    output logic              minv_mdiv,
    output logic              minv_mdiv_en,
    input  logic              minv_mdiv_rdy,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    input  logic [WORD_W-1:0] result_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic              res_last,
    output logic              busy,
    output logic              err,
    output state_t            state_dbg
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            cnt_wrap;
    logic            cnt_en;
    logic            cmd_fire;
    logic            in_fire;
    logic            res_fire;
    logic            rdy_d;
    logic [TW-1:0]   timer;

    mdiv_word_cnt #(.WORDS(WORDS), .CW(CW)) u_word_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cmd_fire),
        .cnt  (cnt),
        .wrap (cnt_wrap)
    );

    // Handshake decode and the combinational result pass-through.
    always_comb begin
        cmd_ready      = (state == IDLE);
        in_ready       = (state == LOAD_P) || (state == LOAD_A) || (state == LOAD_B);
        busy           = (state != IDLE);
        core_out_ready = (state == DRAIN) && res_ready;
        res_valid      = (state == DRAIN) && core_out_valid;
        res_data       = result_out;
        res_last       = res_valid && (cnt == LAST_WORD);
        cmd_fire       = cmd_valid && cmd_ready;
        in_fire        = in_valid && in_ready;
        res_fire       = res_valid && res_ready;
        cnt_en         = in_fire || res_fire;
        state_dbg      = state;
    end

    // Next-state logic; operand order is p, a, then b for division only.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (cmd_valid) state_nxt = LOAD_P;
            LOAD_P: if (cnt_wrap) state_nxt = LOAD_A;
            LOAD_A: if (cnt_wrap) state_nxt = (minv_mdiv == OP_MDIV) ? LOAD_B : START;
            LOAD_B: if (cnt_wrap) state_nxt = START;
            START:  state_nxt = WAIT;
            WAIT: begin
                // Only a fresh rising edge counts; a level left over is stale.
                if (minv_mdiv_rdy && !rdy_d) state_nxt = DRAIN;
                else if (timer == TIMER_MAX) state_nxt = ERR;
            end
            DRAIN:  if (res_fire && cnt_wrap) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            ERR:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, completion-edge history and the WAIT timeout timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rdy_d <= 1'b0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            rdy_d <= minv_mdiv_rdy;
            if (state == START) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Registered core-side outputs and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            datain       <= '0;
            loadp        <= 1'b0;
            loada        <= 1'b0;
            loadb        <= 1'b0;
            minv_mdiv    <= OP_MINV;
            minv_mdiv_en <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (in_fire) begin
                datain <= in_data;
            end
            loadp        <= in_fire && (state == LOAD_P);
            loada        <= in_fire && (state == LOAD_A);
            loadb        <= in_fire && (state == LOAD_B);
            minv_mdiv_en <= (state == START);
            if (cmd_fire) begin
                minv_mdiv <= cmd_op;
            end
            if (cmd_fire) begin
                err <= 1'b0;
            end else if (state == ERR) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdiv_seq_ctrl.sv
// Directed bench for mdiv_seq_ctrl: inverse, division, backpressure, stale
// completion level, reset mid-load and timeout (on a second, short-timeout copy).
module tb_mdiv_seq_ctrl;
    import mdiv_pkg::*;

    localparam int WORDS = 8;
    localparam int W     = 34;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        cmd_valid = 1'b0, cmd_valid_to = 1'b0, cmd_op = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        minv_mdiv_rdy = 1'b0, core_out_valid = 1'b0, res_ready = 1'b1;
    logic [31:0] result_out = '0;

    logic        cmd_ready, in_ready, loadp, loada, loadb, minv_mdiv, minv_mdiv_en;
    logic        core_out_ready, res_valid, res_last, busy, err;
    logic [31:0] datain, res_data;
    state_t      state_dbg;

    logic        cmd_ready_t, in_ready_t, loadp_t, loada_t, loadb_t, minv_mdiv_t, minv_mdiv_en_t;
    logic        core_out_ready_t, res_valid_t, res_last_t, busy_t, err_t;
    logic [31:0] datain_t, res_data_t;
    state_t      state_t_dbg;

    mdiv_seq_ctrl #(.WORDS(WORDS), .TIMEOUT(65535)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .datain(datain),
        .loadp(loadp), .loada(loada), .loadb(loadb), .minv_mdiv(minv_mdiv),
        .minv_mdiv_en(minv_mdiv_en), .minv_mdiv_rdy(minv_mdiv_rdy),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .result_out(result_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_last(res_last), .busy(busy), .err(err),
        .state_dbg(state_dbg)
    );

    mdiv_seq_ctrl #(.WORDS(WORDS), .TIMEOUT(20)) dut_to (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_to), .cmd_ready(cmd_ready_t), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data), .datain(datain_t),
        .loadp(loadp_t), .loada(loada_t), .loadb(loadb_t), .minv_mdiv(minv_mdiv_t),
        .minv_mdiv_en(minv_mdiv_en_t), .minv_mdiv_rdy(minv_mdiv_rdy),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready_t),
        .result_out(result_out), .res_valid(res_valid_t), .res_ready(res_ready),
        .res_data(res_data_t), .res_last(res_last_t), .busy(busy_t), .err(err_t),
        .state_dbg(state_t_dbg)
    );

    // ---------------- scoreboard state ----------------
    int             n_tests = 0;
    int             n_fail  = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   obs_q[$];
    logic [32:0]    res_q[$];
    int             en_cnt = 0, en_cyc = 0, last_strobe_cyc = 0, multi_cnt = 0, rv_t_cnt = 0;
    logic           mv_or = 1'b0, mv_and = 1'b1;

    // Monitor: records strobes {kind, datain}, start pulses and result transfers.
    always @(negedge clk) begin
        if (loadp) obs_q.push_back({2'd0, datain});
        if (loada) obs_q.push_back({2'd1, datain});
        if (loadb) obs_q.push_back({2'd2, datain});
        if ((int'(loadp) + int'(loada) + int'(loadb)) > 1) multi_cnt++;
        if (loadp || loada || loadb) last_strobe_cyc = cyc;
        if (minv_mdiv_en) begin
            en_cnt++;
            en_cyc = cyc;
        end
        if (busy) begin
            mv_or  = mv_or | minv_mdiv;
            mv_and = mv_and & minv_mdiv;
        end
        if (res_valid && res_ready) res_q.push_back({res_last, res_data});
        if (res_valid_t) rv_t_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input int k);
        logic [31:0] base;
        base = (k / WORDS == 0) ? 32'h1 : (k / WORDS == 1) ? 32'h11 : 32'h21;
        return base + 32'(k % WORDS);
    endfunction

    function automatic logic [31:0] res_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic send_cmd(input logic op);
        int g = 0;
        cmd_op    = op;
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 20) begin
            tick();
            g++;
        end
        tick();
        cmd_valid = 1'b0;
        chk("cmd_accept", W'(state_dbg), W'(LOAD_P));
    endtask

    task automatic send_words(input int n, input bit gaps, input bit sel);
        int   i = 0;
        int   g = 0;
        logic f;
        while (i < n && g < 400) begin
            in_valid = gaps ? ((g % 2) == 0) : 1'b1;
            in_data  = word_at(i);
            #1;
            f = in_valid && (sel ? in_ready_t : in_ready);
            tick();
            if (f) i++;
            g++;
        end
        in_valid = 1'b0;
        chk("words_accepted", W'(i), W'(n));
    endtask

    task automatic run_op(input logic op, input bit gaps, input bit stall, input bit stale,
                          input int rdy_delay);
        int   n_words;
        int   i;
        int   g;
        int   stall_left;
        logic f;
        obs_q.delete();
        exp_q.delete();
        res_q.delete();
        en_cnt    = 0;
        multi_cnt = 0;
        mv_or     = 1'b0;
        mv_and    = 1'b1;
        n_words   = (op == OP_MINV) ? 2 * WORDS : 3 * WORDS;
        for (int k = 0; k < n_words; k++) exp_q.push_back({2'(k / WORDS), word_at(k)});
        if (stale) minv_mdiv_rdy = 1'b1;

        send_cmd(op);
        send_words(n_words, gaps, 1'b0);

        g = 0;
        while (en_cnt == 0 && g < 10) begin
            tick();
            g++;
        end
        chk("in_wait", W'(state_dbg), W'(WAIT));

        if (stale) begin
            repeat (5) tick();
            chk("stale_ignored", W'(state_dbg), W'(WAIT));
            minv_mdiv_rdy = 1'b0;
            repeat (49) tick();
            chk("still_wait", W'(state_dbg), W'(WAIT));
        end else begin
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            chk("cmd_ignored_busy", W'(state_dbg), W'(WAIT));
            repeat (rdy_delay) tick();
        end
        minv_mdiv_rdy = 1'b1;
        #1;
        chk("pre_rise_wait", W'(state_dbg), W'(WAIT));
        tick();
        chk("drain_entered", W'(state_dbg), W'(DRAIN));

        i          = 0;
        g          = 0;
        stall_left = stall ? 3 : 0;
        core_out_valid = 1'b1;
        while (i < WORDS && g < 400) begin
            result_out = res_word(i);
            if (i == 3 && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            #1;
            if (!res_ready) begin
                chk("core_ready_stall", W'(core_out_ready), W'(1'b0));
                chk("res_valid_stall", W'(res_valid), W'(1'b1));
            end
            f = core_out_valid && core_out_ready;
            tick();
            if (f) i++;
            g++;
        end
        core_out_valid = 1'b0;
        res_ready      = 1'b1;
        minv_mdiv_rdy  = 1'b0;
        chk("drain_words", W'(i), W'(WORDS));
        chk("done_state", W'(state_dbg), W'(DONE));
        chk("done_busy", W'(busy), W'(1'b1));
        tick();
        chk("idle_state", W'(state_dbg), W'(IDLE));
        chk("idle_busy", W'(busy), W'(1'b0));
        chk("idle_cmd_ready", W'(cmd_ready), W'(1'b1));

        chk("strobe_count", W'(obs_q.size()), W'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk($sformatf("strobe[%0d]", k), obs_q[k], exp_q[k]);
        chk("multi_strobe", W'(multi_cnt), W'(0));
        chk("en_pulses", W'(en_cnt), W'(1));
        chk("en_after_last_strobe", W'(en_cyc), W'(last_strobe_cyc + 1));
        chk("minv_mdiv_or", W'(mv_or), W'(op));
        chk("minv_mdiv_and", W'(mv_and), W'(op));
        chk("res_count", W'(res_q.size()), W'(WORDS));
        for (int k = 0; k < WORDS && k < res_q.size(); k++)
            chk($sformatf("res[%0d]", k), W'(res_q[k]), W'({(k == WORDS - 1), res_word(k)}));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int wait_cnt;
        int g;

        // Reset values, with inputs that would otherwise make outputs move.
        core_out_valid = 1'b1;
        res_ready      = 1'b1;
        repeat (2) tick();
        chk("rst_state", W'(state_dbg), W'(IDLE));
        chk("rst_datain", W'(datain), W'(32'h0));
        chk("rst_strobes", W'({loadp, loada, loadb}), W'(3'b000));
        chk("rst_minv_mdiv", W'(minv_mdiv), W'(1'b1));
        chk("rst_en", W'(minv_mdiv_en), W'(1'b0));
        chk("rst_err", W'(err), W'(1'b0));
        chk("rst_busy", W'(busy), W'(1'b0));
        chk("rst_cmd_ready", W'(cmd_ready), W'(1'b1));
        chk("rst_in_ready", W'(in_ready), W'(1'b0));
        chk("rst_res_valid", W'(res_valid), W'(1'b0));
        chk("rst_core_ready", W'(core_out_ready), W'(1'b0));
        core_out_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Inverse, back-to-back words, completion 100 cycles after start.
        run_op(OP_MINV, 1'b0, 1'b0, 1'b0, 100);
        // Division: p, a, b.
        run_op(OP_MDIV, 1'b0, 1'b0, 1'b0, 10);
        // Division with in_valid gaps and a 3-cycle result stall.
        run_op(OP_MDIV, 1'b1, 1'b1, 1'b0, 5);
        // Inverse with completion level still high from before.
        run_op(OP_MINV, 1'b0, 1'b0, 1'b1, 0);

        // Reset during LOAD_A after 3 a-words of a division command.
        send_cmd(OP_MDIV);
        send_words(WORDS + 3, 1'b0, 1'b0);
        chk("mid_loada_strobe", W'(loada), W'(1'b1));
        rst = 1'b0;
        #1;
        chk("midrst_state", W'(state_dbg), W'(IDLE));
        chk("midrst_loada", W'(loada), W'(1'b0));
        chk("midrst_datain", W'(datain), W'(32'h0));
        chk("midrst_minv_mdiv", W'(minv_mdiv), W'(1'b1));
        chk("midrst_busy", W'(busy), W'(1'b0));
        repeat (2) tick();
        rst = 1'b1;
        tick();
        run_op(OP_MINV, 1'b0, 1'b0, 1'b0, 3);

        // Timeout on the TIMEOUT=20 copy; completion never rises.
        rv_t_cnt       = 0;
        minv_mdiv_rdy  = 1'b0;
        core_out_valid = 1'b1;
        cmd_op         = OP_MINV;
        cmd_valid_to   = 1'b1;
        tick();
        cmd_valid_to   = 1'b0;
        chk("to_cmd_accept", W'(state_t_dbg), W'(LOAD_P));
        send_words(2 * WORDS, 1'b0, 1'b1);
        wait_cnt = 0;
        g        = 0;
        while (state_t_dbg != ERR && g < 200) begin
            if (state_t_dbg == WAIT) wait_cnt++;
            tick();
            g++;
        end
        chk("to_wait_cycles", W'(wait_cnt), W'(21));
        chk("to_err_state", W'(state_t_dbg), W'(ERR));
        tick();
        chk("to_idle", W'(state_t_dbg), W'(IDLE));
        chk("to_err_set", W'(err_t), W'(1'b1));
        chk("to_busy", W'(busy_t), W'(1'b0));
        repeat (3) tick();
        chk("to_err_sticky", W'(err_t), W'(1'b1));
        chk("to_no_res_valid", W'(rv_t_cnt), W'(0));
        core_out_valid = 1'b0;
        cmd_valid_to   = 1'b1;
        tick();
        cmd_valid_to   = 1'b0;
        chk("to_err_cleared", W'(err_t), W'(1'b0));
        chk("to_new_cmd", W'(state_t_dbg), W'(LOAD_P));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
